// File: rtl/pcr_unit.sv
// rtl/pcr_unit.sv - privileged control register file with trap/ERET status stack,
// prioritised interrupts, free-running timer and tohost/fromhost mailbox.
module pcr_unit #(
   parameter int NUM_IRQ    = 8,
   parameter int EVEC_ALIGN = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               pcr_en,
   input  logic [1:0]         cmd,
   input  logic [4:0]         pcr_addr,
   input  logic [31:0]        pcr_wdata,
   input  logic [11:0]        imm,
   output logic [31:0]        pcr_rdata,
   input  logic               trap_valid,
   input  logic [4:0]         trap_cause,
   input  logic [31:0]        trap_pc,
   input  logic               trap_badvaddr_valid,
   input  logic [31:0]        trap_badvaddr,
   input  logic               eret,
   input  logic [NUM_IRQ-2:0] ext_irq,
   output logic               irq_take,
   output logic [4:0]         irq_cause,
   output logic [31:0]        evec,
   output logic [31:0]        epc,
   output logic [31:0]        ptbr,
   output logic               supervisor,
   output logic               vm_enable,
   output logic               flush_tlb,
   output logic [31:0]        tohost,
   output logic               tohost_valid,
   input  logic               tohost_ack,
   input  logic               fromhost_we,
   input  logic [31:0]        fromhost_wdata
);
   localparam logic [4:0] A_STATUS   = 5'd0;
   localparam logic [4:0] A_EPC      = 5'd1;
   localparam logic [4:0] A_BADVADDR = 5'd2;
   localparam logic [4:0] A_EVEC     = 5'd3;
   localparam logic [4:0] A_COUNT    = 5'd4;
   localparam logic [4:0] A_COMPARE  = 5'd5;
   localparam logic [4:0] A_CAUSE    = 5'd6;
   localparam logic [4:0] A_PTBR     = 5'd7;
   localparam logic [4:0] A_K0       = 5'd12;
   localparam logic [4:0] A_K1       = 5'd13;
   localparam logic [4:0] A_TOHOST   = 5'd30;
   localparam logic [4:0] A_FROMHOST = 5'd31;

   localparam int B_ET = 0;
   localparam int B_PS = 4;
   localparam int B_S  = 5;
   localparam int B_VM = 8;

   localparam logic [31:0] IM_MASK      = ((32'd1 << NUM_IRQ) - 32'd1) << 16;
   localparam logic [31:0] STATUS_WMASK = 32'h0000_0131 | IM_MASK;
   localparam logic [31:0] EVEC_MASK    = ~((32'd1 << EVEC_ALIGN) - 32'd1);

   logic [31:0] status_q, status_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
   logic [31:0] evec_q, evec_d, count_q, count_d, compare_q, compare_d;
   logic [31:0] cause_q, cause_d, ptbr_q, ptbr_d, k0_q, k0_d, k1_q, k1_d;
   logic [31:0] tohost_q, tohost_d, fromhost_q, fromhost_d;
   logic        timer_pending_q, timer_pending_d;
   logic        tohost_valid_q, tohost_valid_d;
   logic        flush_q, flush_d;

   logic [NUM_IRQ-1:0] ip, irq_pend;
   logic [31:0]        status_rd, old_val, imm_sext, wval, wsel;
   logic               wen;

   assign ip        = {timer_pending_q, ext_irq};
   assign status_rd = status_q | (32'(ip) << 24);

   assign irq_pend = status_q[16 +: NUM_IRQ] & ip;
   assign irq_take = status_q[B_ET] && (irq_pend != '0);

   // Scan downward so the lowest pending line ends up winning.
   always_comb begin
      irq_cause = 5'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq_pend[i]) irq_cause = 5'(16 + i);
      end
      if (!status_q[B_ET]) irq_cause = 5'd0;
   end

   always_comb begin
      case (pcr_addr)
         A_STATUS:   old_val = status_rd;
         A_EPC:      old_val = epc_q;
         A_BADVADDR: old_val = badvaddr_q;
         A_EVEC:     old_val = evec_q;
         A_COUNT:    old_val = count_q;
         A_COMPARE:  old_val = compare_q;
         A_CAUSE:    old_val = cause_q;
         A_PTBR:     old_val = ptbr_q;
         A_K0:       old_val = k0_q;
         A_K1:       old_val = k1_q;
         A_TOHOST:   old_val = tohost_q;
         A_FROMHOST: old_val = fromhost_q;
         default:    old_val = 32'd0;
      endcase
   end

   assign pcr_rdata = pcr_en ? old_val : 32'd0;
   assign imm_sext  = {{20{imm[11]}}, imm};

   always_comb begin
      case (cmd)
         2'b01:   wval = pcr_wdata;
         2'b10:   wval = old_val | imm_sext;
         2'b11:   wval = old_val & ~imm_sext;
         default: wval = old_val;
      endcase
   end

   assign wen  = pcr_en && !stall && (cmd != 2'b00);
   assign wsel = wen ? (32'd1 << pcr_addr) : 32'd0;

   always_comb begin
      status_d        = status_q;
      epc_d           = wsel[A_EPC]      ? wval : epc_q;
      badvaddr_d      = badvaddr_q;
      evec_d          = wsel[A_EVEC]     ? (wval & EVEC_MASK) : evec_q;
      count_d         = wsel[A_COUNT]    ? wval : count_q + 32'd1;
      compare_d       = wsel[A_COMPARE]  ? wval : compare_q;
      cause_d         = cause_q;
      ptbr_d          = wsel[A_PTBR]     ? wval : ptbr_q;
      k0_d            = wsel[A_K0]       ? wval : k0_q;
      k1_d            = wsel[A_K1]       ? wval : k1_q;
      tohost_d        = tohost_q;
      tohost_valid_d  = tohost_valid_q;
      fromhost_d      = fromhost_we ? fromhost_wdata : (wsel[A_FROMHOST] ? wval : fromhost_q);
      timer_pending_d = wsel[A_COMPARE] ? 1'b0 :
                        (count_q == compare_q) ? 1'b1 : timer_pending_q;

      if (wsel[A_TOHOST]) begin
         tohost_d       = wval;
         tohost_valid_d = 1'b1;
      end else if (tohost_ack) begin
         tohost_d       = 32'd0;
         tohost_valid_d = 1'b0;
      end

      // Trap and ERET own STATUS outright; a same-cycle STATUS write is dropped.
      if (trap_valid) begin
         status_d[B_PS] = status_q[B_S];
         status_d[B_S]  = 1'b1;
         status_d[B_ET] = 1'b0;
         epc_d          = trap_pc;
         cause_d        = {27'd0, trap_cause};
         if (trap_badvaddr_valid) badvaddr_d = trap_badvaddr;
      end else if (eret) begin
         status_d[B_S]  = status_q[B_PS];
         status_d[B_ET] = 1'b1;
      end else if (wsel[A_STATUS]) begin
         status_d = wval & STATUS_WMASK;
      end

      flush_d = wsel[A_PTBR] || (status_d[B_VM] != status_q[B_VM]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         status_q        <= 32'h0000_0020;
         epc_q           <= 32'd0;
         badvaddr_q      <= 32'd0;
         evec_q          <= 32'd0;
         count_q         <= 32'd0;
         compare_q       <= 32'd0;
         cause_q         <= 32'd0;
         ptbr_q          <= 32'd0;
         k0_q            <= 32'd0;
         k1_q            <= 32'd0;
         tohost_q        <= 32'd0;
         fromhost_q      <= 32'd0;
         timer_pending_q <= 1'b0;
         tohost_valid_q  <= 1'b0;
         flush_q         <= 1'b0;
      end else begin
         status_q        <= status_d;
         epc_q           <= epc_d;
         badvaddr_q      <= badvaddr_d;
         evec_q          <= evec_d;
         count_q         <= count_d;
         compare_q       <= compare_d;
         cause_q         <= cause_d;
         ptbr_q          <= ptbr_d;
         k0_q            <= k0_d;
         k1_q            <= k1_d;
         tohost_q        <= tohost_d;
         fromhost_q      <= fromhost_d;
         timer_pending_q <= timer_pending_d;
         tohost_valid_q  <= tohost_valid_d;
         flush_q         <= flush_d;
      end
   end

   assign evec         = evec_q;
   assign epc          = epc_q;
   assign ptbr         = ptbr_q;
   assign supervisor   = status_q[B_S];
   assign vm_enable    = status_q[B_VM];
   assign flush_tlb    = flush_q;
   assign tohost       = tohost_q;
   assign tohost_valid = tohost_valid_q;
endmodule

// File: tb/tb_pcr_unit.sv
// tb/tb_pcr_unit.sv - directed vectors, corner sequences and random stimulus
// against a register-array reference model of pcr_unit.
module tb_pcr_unit;
   localparam int NI = 8;

   logic          clk = 1'b0;
   logic          reset, stall, pcr_en;
   logic [1:0]    cmd;
   logic [4:0]    pcr_addr;
   logic [31:0]   pcr_wdata;
   logic [11:0]   imm;
   logic [31:0]   pcr_rdata;
   logic          trap_valid, trap_badvaddr_valid, eret;
   logic [4:0]    trap_cause;
   logic [31:0]   trap_pc, trap_badvaddr;
   logic [NI-2:0] ext_irq;
   logic          irq_take;
   logic [4:0]    irq_cause;
   logic [31:0]   evec, epc, ptbr, tohost;
   logic          supervisor, vm_enable, flush_tlb, tohost_valid;
   logic          tohost_ack, fromhost_we;
   logic [31:0]   fromhost_wdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pcr_unit #(.NUM_IRQ(NI), .EVEC_ALIGN(2)) dut (
      .clk(clk), .reset(reset), .stall(stall), .pcr_en(pcr_en), .cmd(cmd),
      .pcr_addr(pcr_addr), .pcr_wdata(pcr_wdata), .imm(imm), .pcr_rdata(pcr_rdata),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
      .trap_badvaddr_valid(trap_badvaddr_valid), .trap_badvaddr(trap_badvaddr),
      .eret(eret), .ext_irq(ext_irq), .irq_take(irq_take), .irq_cause(irq_cause),
      .evec(evec), .epc(epc), .ptbr(ptbr), .supervisor(supervisor),
      .vm_enable(vm_enable), .flush_tlb(flush_tlb), .tohost(tohost),
      .tohost_valid(tohost_valid), .tohost_ack(tohost_ack),
      .fromhost_we(fromhost_we), .fromhost_wdata(fromhost_wdata)
   );

   // Reference model: PCR file as an address-indexed array.
   localparam logic [31:0] MAPPED = 32'hC000_30FF;
   localparam logic [31:0] WMASK  = 32'h00FF_0131;
   logic [31:0] m_regs [32];
   logic        m_tp, m_tovalid, m_flush;

   function automatic logic [NI-1:0] m_ip();
      return {m_tp, ext_irq};
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (!MAPPED[a]) return 32'd0;
      if (a == 5'd0) return m_regs[0] | ({24'd0, m_ip()} << 24);
      return m_regs[a];
   endfunction

   task automatic m_clock();
      logic [31:0] nxt [32];
      logic [31:0] old, sx, wv, st;
      logic        commit, tv;
      if (reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_regs[0] = 32'h20;
         m_tp = 1'b0; m_tovalid = 1'b0; m_flush = 1'b0;
         return;
      end
      old = m_read(pcr_addr);
      sx  = {{20{imm[11]}}, imm};
      case (cmd)
         2'd1:    wv = pcr_wdata;
         2'd2:    wv = old | sx;
         2'd3:    wv = old & ~sx;
         default: wv = old;
      endcase
      commit = pcr_en && !stall && cmd != 2'd0 && MAPPED[pcr_addr]
               && pcr_addr != 5'd2 && pcr_addr != 5'd6;
      for (int i = 0; i < 32; i++) nxt[i] = m_regs[i];
      tv = m_tovalid;
      if (commit) begin
         if (pcr_addr == 5'd0)      nxt[0] = wv & WMASK;
         else if (pcr_addr == 5'd3) nxt[3] = wv & ~32'd3;
         else                       nxt[pcr_addr] = wv;
      end
      if (!(commit && pcr_addr == 5'd4)) nxt[4] = m_regs[4] + 32'd1;
      if (commit && pcr_addr == 5'd30) tv = 1'b1;
      else if (tohost_ack) begin nxt[30] = 32'd0; tv = 1'b0; end
      if (fromhost_we) nxt[31] = fromhost_wdata;
      st = m_regs[0];
      if (trap_valid) begin
         nxt[1] = trap_pc;
         nxt[6] = {27'd0, trap_cause};
         if (trap_badvaddr_valid) nxt[2] = trap_badvaddr;
         st[4] = st[5]; st[5] = 1'b1; st[0] = 1'b0;
         nxt[0] = st;
      end else if (eret) begin
         st[5] = st[4]; st[0] = 1'b1;
         nxt[0] = st;
      end
      if (commit && pcr_addr == 5'd5) m_tp = 1'b0;
      else if (m_regs[4] == m_regs[5]) m_tp = 1'b1;
      m_flush = (commit && pcr_addr == 5'd7) || (nxt[0][8] != m_regs[0][8]);
      m_tovalid = tv;
      for (int i = 0; i < 32; i++) m_regs[i] = nxt[i];
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_model();
      logic [7:0] p, low;
      logic       take;
      logic [4:0] cz;
      p    = m_regs[0][23:16] & m_ip();
      take = m_regs[0][0] && (p != 8'd0);
      low  = p & (~p + 8'd1);
      cz   = take ? 5'(16 + $clog2(low)) : 5'd0;
      chk("m_rdata", pcr_rdata, pcr_en ? m_read(pcr_addr) : 32'd0);
      chk("m_irq_take", 32'(irq_take), 32'(take));
      chk("m_irq_cause", 32'(irq_cause), 32'(cz));
      chk("m_evec", evec, m_regs[3]);
      chk("m_epc", epc, m_regs[1]);
      chk("m_ptbr", ptbr, m_regs[7]);
      chk("m_supervisor", 32'(supervisor), 32'(m_regs[0][5]));
      chk("m_vm_enable", 32'(vm_enable), 32'(m_regs[0][8]));
      chk("m_flush_tlb", 32'(flush_tlb), 32'(m_flush));
      chk("m_tohost", tohost, m_regs[30]);
      chk("m_tohost_valid", 32'(tohost_valid), 32'(m_tovalid));
   endtask

   task automatic pre();
      @(negedge clk);
      check_model();
   endtask

   task automatic post();
      @(posedge clk);
      m_clock();
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; stall = 1'b0; pcr_en = 1'b0; cmd = 2'd0; pcr_addr = 5'd0;
      pcr_wdata = 32'd0; imm = 12'd0; trap_valid = 1'b0; trap_cause = 5'd0;
      trap_pc = 32'd0; trap_badvaddr_valid = 1'b0; trap_badvaddr = 32'd0;
      eret = 1'b0; ext_irq = '0; tohost_ack = 1'b0; fromhost_we = 1'b0;
      fromhost_wdata = 32'd0;
   endtask

   task automatic set_pcr(input logic [1:0] c, input logic [4:0] a,
                          input logic [31:0] wd, input logic [11:0] im);
      pcr_en = 1'b1; cmd = c; pcr_addr = a; pcr_wdata = wd; imm = im;
   endtask

   typedef struct {
      logic [1:0]  cmd;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [11:0] imm;
      logic [31:0] exp;
   } vec_t;
   vec_t vt [12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic found;
      vt[0]  = '{2'd0, 5'd0, 32'h0,         12'h000, 32'h0000_0020};
      vt[1]  = '{2'd0, 5'd4, 32'h0,         12'h000, 32'd1};
      vt[2]  = '{2'd0, 5'd4, 32'h0,         12'h000, 32'd2};
      vt[3]  = '{2'd1, 5'd3, 32'h0000_1237, 12'h000, 32'h0};
      vt[4]  = '{2'd0, 5'd3, 32'h0,         12'h000, 32'h0000_1234};
      vt[5]  = '{2'd2, 5'd0, 32'h0,         12'h001, 32'h8000_0020};
      vt[6]  = '{2'd3, 5'd0, 32'h0,         12'h020, 32'h8000_0021};
      vt[7]  = '{2'd0, 5'd0, 32'h0,         12'h000, 32'h8000_0001};
      vt[8]  = '{2'd1, 5'd5, 32'd20,        12'h000, 32'h0};
      vt[9]  = '{2'd1, 5'd4, 32'd10,        12'h000, 32'd9};
      vt[10] = '{2'd0, 5'd0, 32'h0,         12'h000, 32'h0000_0001};
      vt[11] = '{2'd1, 5'd0, 32'h0080_0001, 12'h000, 32'h0000_0001};

      idle();
      reset = 1'b1;
      post();
      pre(); post();
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         set_pcr(vt[i].cmd, vt[i].addr, vt[i].wdata, vt[i].imm);
         pre();
         chk($sformatf("vec%0d_rdata", i), pcr_rdata, vt[i].exp);
         post();
      end

      // Timer match at COUNT==20 raises the timer interrupt one cycle later.
      found = 1'b0;
      set_pcr(2'd0, 5'd4, 32'd0, 12'd0);
      for (int k = 0; k < 30 && !found; k++) begin
         pre();
         if (pcr_rdata == 32'd20) begin
            found = 1'b1;
            chk("timer_irq_before", 32'(irq_take), 32'd0);
         end
         post();
      end
      chk("timer_count20_seen", 32'(found), 32'd1);
      set_pcr(2'd1, 5'd5, 32'hFFFF_0000, 12'd0);
      pre();
      chk("timer_irq_take", 32'(irq_take), 32'd1);
      chk("timer_irq_cause", 32'(irq_cause), 32'd23);
      post();
      idle();
      pre(); chk("timer_irq_cleared", 32'(irq_take), 32'd0); post();

      // External lines: lowest enabled pending line wins.
      ext_irq = 7'b0001010;
      set_pcr(2'd1, 5'd0, 32'h00FF_0001, 12'd0);
      pre(); post();
      pcr_en = 1'b0;
      pre();
      chk("ext_irq_take", 32'(irq_take), 32'd1);
      chk("ext_irq_cause17", 32'(irq_cause), 32'd17);
      post();
      set_pcr(2'd1, 5'd0, 32'h00FD_0001, 12'd0);
      pre(); post();
      pcr_en = 1'b0;
      pre(); chk("ext_irq_cause19", 32'(irq_cause), 32'd19); post();
      idle();

      // COMPARE=0 matches once COUNT wraps.
      set_pcr(2'd1, 5'd5, 32'd0, 12'd0);          pre(); post();
      set_pcr(2'd1, 5'd4, 32'hFFFF_FFFE, 12'd0);  pre(); post();
      set_pcr(2'd1, 5'd0, 32'h0080_0001, 12'd0);  pre(); post();
      set_pcr(2'd0, 5'd4, 32'd0, 12'd0);
      pre(); chk("wrap_count_ff", pcr_rdata, 32'hFFFF_FFFF); post();
      pre();
      chk("wrap_count_0", pcr_rdata, 32'd0);
      chk("wrap_irq_low", 32'(irq_take), 32'd0);
      post();
      set_pcr(2'd1, 5'd5, 32'hFFFF_0000, 12'd0);
      pre();
      chk("wrap_irq_take", 32'(irq_take), 32'd1);
      chk("wrap_irq_cause", 32'(irq_cause), 32'd23);
      post();

      // Trap with a simultaneous K0 write, then ERET.
      set_pcr(2'd1, 5'd0, 32'h0000_0021, 12'd0);  pre(); post();
      set_pcr(2'd1, 5'd12, 32'h0000_0055, 12'd0);
      trap_valid = 1'b1; trap_cause = 5'd5; trap_pc = 32'h400;
      trap_badvaddr_valid = 1'b1; trap_badvaddr = 32'hDEAD_0000;
      pre(); post();
      idle();
      set_pcr(2'd0, 5'd1, 32'd0, 12'd0);  pre(); chk("trap_epc", pcr_rdata, 32'h400); post();
      set_pcr(2'd0, 5'd6, 32'd0, 12'd0);  pre(); chk("trap_cause", pcr_rdata, 32'd5); post();
      set_pcr(2'd0, 5'd0, 32'd0, 12'd0);  pre(); chk("trap_status", pcr_rdata, 32'h30); post();
      set_pcr(2'd0, 5'd2, 32'd0, 12'd0);  pre(); chk("trap_badv", pcr_rdata, 32'hDEAD_0000); post();
      set_pcr(2'd0, 5'd12, 32'd0, 12'd0); pre(); chk("trap_k0", pcr_rdata, 32'h55); post();
      idle(); eret = 1'b1;                pre(); post();
      idle();
      set_pcr(2'd0, 5'd0, 32'd0, 12'd0);  pre(); chk("eret_status", pcr_rdata, 32'h31); post();

      // tohost handshake.
      set_pcr(2'd1, 5'd30, 32'h0000_ABCD, 12'd0); pre(); post();
      idle(); tohost_ack = 1'b1;
      pre();
      chk("tohost_valid_set", 32'(tohost_valid), 32'd1);
      chk("tohost_value", tohost, 32'h0000_ABCD);
      post();
      idle();
      pre();
      chk("tohost_ack_valid", 32'(tohost_valid), 32'd0);
      chk("tohost_ack_value", tohost, 32'd0);
      post();

      // Stalled PTBR write is dropped; unstalled one flushes once.
      set_pcr(2'd1, 5'd7, 32'h0000_1000, 12'd0); stall = 1'b1; pre(); post();
      idle();
      pre();
      chk("ptbr_stall_val", ptbr, 32'd0);
      chk("ptbr_stall_flush", 32'(flush_tlb), 32'd0);
      post();
      set_pcr(2'd1, 5'd7, 32'h0000_1000, 12'd0); pre(); post();
      idle();
      pre();
      chk("ptbr_val", ptbr, 32'h0000_1000);
      chk("ptbr_flush", 32'(flush_tlb), 32'd1);
      post();
      pre(); chk("ptbr_flush_pulse", 32'(flush_tlb), 32'd0); post();

      // Reset mid-handshake and coincident with a trap.
      set_pcr(2'd1, 5'd30, 32'h77, 12'd0); pre(); post();
      idle(); reset = 1'b1; trap_valid = 1'b1; trap_pc = 32'h999;
      pre(); chk("rst_tohost_pending", 32'(tohost_valid), 32'd1); post();
      idle();
      pre();
      chk("rst_tohost_valid", 32'(tohost_valid), 32'd0);
      chk("rst_trap_epc", epc, 32'd0);
      chk("rst_supervisor", 32'(supervisor), 32'd1);
      post();

      // Random stimulus against the model.
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] addrs [12];
         addrs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd12, 5'd13, 5'd30, 5'd31};
         reset  = ($urandom_range(0, 299) == 0);
         stall  = ($urandom_range(0, 3) == 0);
         pcr_en = 1'($urandom_range(0, 1));
         cmd    = 2'($urandom);
         pcr_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 11)];
         pcr_wdata = $urandom;
         if (pcr_addr == 5'd5 && $urandom_range(0, 1) == 1)
            pcr_wdata = m_regs[4] + 32'($urandom_range(1, 6));
         imm = 12'($urandom);
         trap_valid = ($urandom_range(0, 15) == 0);
         trap_cause = 5'($urandom);
         trap_pc = $urandom;
         trap_badvaddr_valid = 1'($urandom_range(0, 1));
         trap_badvaddr = $urandom;
         eret = ($urandom_range(0, 15) == 0);
         ext_irq = 7'($urandom);
         tohost_ack = ($urandom_range(0, 7) == 0);
         fromhost_we = ($urandom_range(0, 7) == 0);
         fromhost_wdata = $urandom;
         pre();
         post();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
